rr_arbiter: RTL and testbench

- N-requester arbiter. Each grant is held until the owning requester releases its request.
- Selectable fixed-priority or round-robin mode.
- Optional hold-timeout preemption so one requester cannot starve the others.
- Generalised successor of the 3-channel fixed-priority arbiter. Sits between bus masters and a shared resource (memory port or bus).

---
 rtl/rr_arbiter.sv | 138 +++++++++++++
 tb/tb_rr_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : N-requester hold-until-release arbiter with fixed-priority or
//                round-robin selection and optional hold-timeout preemption.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N        = 4,
    parameter int RR       = 1,
    parameter int MAX_HOLD = 0,
    parameter int HW       = 8,
    localparam int IW      = (N > 2) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_id,
    output logic          preempt
);

    localparam logic [0:0]    c_idle     = 1'b0;
    localparam logic [0:0]    c_busy     = 1'b1;
    localparam logic [N-1:0]  c_one      = N'(1);
    localparam logic [HW-1:0] c_max_hold = HW'(MAX_HOLD);
    localparam logic [IW-1:0] c_last     = IW'(N - 1);

    logic [0:0]    r_state;
    logic [IW-1:0] r_ptr;
    logic [HW-1:0] r_hold;
    logic [N-1:0]  r_mask;
    logic [N-1:0]  r_gnt;
    logic          r_gnt_valid;
    logic [IW-1:0] r_gnt_id;
    logic          r_preempt;

    logic [N-1:0]  w_elig;
    logic [IW-1:0] w_base;
    logic [IW-1:0] w_win;
    logic          w_found;
    logic [IW-1:0] w_next_ptr;
    logic          w_own_req;
    logic          w_others;
    logic          w_timeout;
    int            w_idx;

    assign w_elig = req & ~r_mask;

    // Fixed priority is a rotating scan that always starts at index 0.
    if (RR != 0) begin : g_rr_base
        assign w_base = r_ptr;
    end else begin : g_fixed_base
        assign w_base = '0;
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(w_base) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!w_found && w_elig[w_idx[IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[IW-1:0];
            end
        end
    end

    assign w_next_ptr = (w_win == c_last) ? '0 : w_win + IW'(1);
    assign w_own_req  = req[r_gnt_id];
    assign w_others   = |(req & ~r_gnt);
    // Release is checked first in the BUSY branch, so a same-cycle drop wins.
    assign w_timeout  = (c_max_hold != '0) && (r_hold >= c_max_hold)
                        && w_own_req && w_others;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_idle;
            r_ptr       <= '0;
            r_hold      <= '0;
            r_mask      <= '0;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_preempt   <= 1'b0;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                c_idle: begin
                    r_mask <= '0;
                    if (w_found) begin
                        r_gnt       <= c_one << w_win;
                        r_gnt_id    <= w_win;
                        r_gnt_valid <= 1'b1;
                        r_hold      <= HW'(1);
                        r_ptr       <= w_next_ptr;
                        r_state     <= c_busy;
                    end
                end
                c_busy: begin
                    if (!w_own_req) begin
                        r_gnt       <= '0;
                        r_gnt_valid <= 1'b0;
                        r_gnt_id    <= '0;
                        r_hold      <= '0;
                        r_state     <= c_idle;
                    end else if (w_timeout) begin
                        r_gnt       <= '0;
                        r_gnt_valid <= 1'b0;
                        r_gnt_id    <= '0;
                        r_hold      <= '0;
                        r_mask      <= c_one << r_gnt_id;
                        r_preempt   <= 1'b1;
                        r_state     <= c_idle;
                    end else if (r_hold != '1) begin
                        r_hold <= r_hold + HW'(1);
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign gnt_id    = r_gnt_id;
    assign preempt   = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for rr_arbiter: four instances covering round-robin,
// fixed priority, timeout preemption and release/timeout tie with saturation.
module tb_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_a = '0, req_b = '0, req_c = '0, req_d = '0;
    logic [3:0] gnt_a, gnt_b, gnt_c, gnt_d;
    logic       v_a, v_b, v_c, v_d;
    logic [1:0] id_a, id_b, id_c, id_d;
    logic       pre_a, pre_b, pre_c, pre_d;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rr_arbiter #(.N(4), .RR(1), .MAX_HOLD(0), .HW(8)) u_rr (
        .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a),
        .gnt_valid(v_a), .gnt_id(id_a), .preempt(pre_a));

    rr_arbiter #(.N(4), .RR(0), .MAX_HOLD(0), .HW(8)) u_fp (
        .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b),
        .gnt_valid(v_b), .gnt_id(id_b), .preempt(pre_b));

    rr_arbiter #(.N(4), .RR(0), .MAX_HOLD(4), .HW(8)) u_to (
        .clk(clk), .rst(rst), .req(req_c), .gnt(gnt_c),
        .gnt_valid(v_c), .gnt_id(id_c), .preempt(pre_c));

    rr_arbiter #(.N(4), .RR(0), .MAX_HOLD(2), .HW(3)) u_tie (
        .clk(clk), .rst(rst), .req(req_d), .gnt(gnt_d),
        .gnt_valid(v_d), .gnt_id(id_d), .preempt(pre_d));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected valid/id are derived from the expected grant vector.
    task automatic chk_out(input string tag, input logic [3:0] g, input logic v,
                           input logic [1:0] id, input logic p,
                           input logic [3:0] eg, input logic ep);
        logic [1:0] eid;
        eid = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (eg[i]) eid = 2'(i);
        end
        chk({tag, "/gnt"}, 32'(g), 32'(eg));
        chk({tag, "/valid"}, 32'(v), 32'(|eg));
        chk({tag, "/id"}, 32'(id), 32'(eid));
        chk({tag, "/preempt"}, 32'(p), 32'(ep));
    endtask

    initial begin
        tick();
        tick();
        chk_out("reset_a", gnt_a, v_a, id_a, pre_a, 4'b0000, 1'b0);
        chk_out("reset_c", gnt_c, v_c, id_c, pre_c, 4'b0000, 1'b0);
        rst = 1'b0;

        // Single request and release
        req_a = 4'b0100;
        tick();
        chk_out("single_grant", gnt_a, v_a, id_a, pre_a, 4'b0100, 1'b0);
        req_a = 4'b0000;
        tick();
        chk_out("single_release", gnt_a, v_a, id_a, pre_a, 4'b0000, 1'b0);

        // Round-robin rotation from ptr = 0, including the 3 -> 0 wrap
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_a = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            int o;
            o = g % 4;
            tick();
            chk_out("rot_grant", gnt_a, v_a, id_a, pre_a, 4'(1 << o), 1'b0);
            tick();
            chk_out("rot_hold1", gnt_a, v_a, id_a, pre_a, 4'(1 << o), 1'b0);
            tick();
            chk_out("rot_hold2", gnt_a, v_a, id_a, pre_a, 4'(1 << o), 1'b0);
            req_a[o] = 1'b0;
            tick();
            chk_out("rot_dead", gnt_a, v_a, id_a, pre_a, 4'b0000, 1'b0);
            req_a[o] = 1'b1;
        end
        req_a = 4'b0000;
        tick();
        chk_out("rot_end", gnt_a, v_a, id_a, pre_a, 4'b0000, 1'b0);

        // Reset mid-grant with gnt = 1000 and ptr = 0
        req_a = 4'b1000;
        tick();
        chk_out("rstmid_grant3", gnt_a, v_a, id_a, pre_a, 4'b1000, 1'b0);
        req_a = 4'b1001;
        rst = 1'b1;
        tick();
        chk_out("rstmid_drop", gnt_a, v_a, id_a, pre_a, 4'b0000, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("rstmid_after", gnt_a, v_a, id_a, pre_a, 4'b0001, 1'b0);
        req_a = 4'b0000;
        tick();
        // Reset mid-grant with ptr = 2: only a cleared ptr gives index 0
        req_a = 4'b0010;
        tick();
        chk_out("rstptr_grant1", gnt_a, v_a, id_a, pre_a, 4'b0010, 1'b0);
        req_a = 4'b1001;
        rst = 1'b1;
        tick();
        chk_out("rstptr_drop", gnt_a, v_a, id_a, pre_a, 4'b0000, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("rstptr_after", gnt_a, v_a, id_a, pre_a, 4'b0001, 1'b0);
        req_a = 4'b0000;
        tick();

        // Fixed-priority starvation of requesters 2 and 3
        req_b = 4'b1110;
        for (int g = 0; g < 3; g++) begin
            tick();
            chk_out("fp_grant", gnt_b, v_b, id_b, pre_b, 4'b0010, 1'b0);
            tick();
            tick();
            chk_out("fp_hold", gnt_b, v_b, id_b, pre_b, 4'b0010, 1'b0);
            req_b = 4'b1100;
            tick();
            chk_out("fp_dead", gnt_b, v_b, id_b, pre_b, 4'b0000, 1'b0);
            req_b = 4'b1110;
        end
        req_b = 4'b0000;
        tick();

        // Timeout preemption, competitor arriving late
        req_c = 4'b0001;
        tick();
        chk_out("to_grant0", gnt_c, v_c, id_c, pre_c, 4'b0001, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_out("to_lone_hold", gnt_c, v_c, id_c, pre_c, 4'b0001, 1'b0);
        end
        req_c = 4'b0011;
        tick();
        chk_out("to_preempt", gnt_c, v_c, id_c, pre_c, 4'b0000, 1'b1);
        tick();
        chk_out("to_masked_grant1", gnt_c, v_c, id_c, pre_c, 4'b0010, 1'b0);
        req_c = 4'b0001;
        tick();
        chk_out("to_release1", gnt_c, v_c, id_c, pre_c, 4'b0000, 1'b0);
        tick();
        chk_out("to_back_to0", gnt_c, v_c, id_c, pre_c, 4'b0001, 1'b0);
        req_c = 4'b0000;
        tick();
        chk_out("to_idle", gnt_c, v_c, id_c, pre_c, 4'b0000, 1'b0);

        // Timeout threshold with a competitor present from the start
        req_c = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_out("th_hold", gnt_c, v_c, id_c, pre_c, 4'b0001, 1'b0);
        end
        tick();
        chk_out("th_preempt", gnt_c, v_c, id_c, pre_c, 4'b0000, 1'b1);
        tick();
        chk_out("th_grant1", gnt_c, v_c, id_c, pre_c, 4'b0010, 1'b0);
        req_c = 4'b0000;
        tick();

        // Release and timeout on the same cycle: release wins
        req_d = 4'b0001;
        tick();
        chk_out("tie_grant0", gnt_d, v_d, id_d, pre_d, 4'b0001, 1'b0);
        req_d = 4'b0011;
        tick();
        chk_out("tie_below_limit", gnt_d, v_d, id_d, pre_d, 4'b0001, 1'b0);
        req_d = 4'b0010;
        tick();
        chk_out("tie_release", gnt_d, v_d, id_d, pre_d, 4'b0000, 1'b0);
        tick();
        chk_out("tie_grant1", gnt_d, v_d, id_d, pre_d, 4'b0010, 1'b0);
        req_d = 4'b0000;
        tick();

        // Lone owner for 23 cycles: a 3-bit counter that wrapped would read 0
        req_d = 4'b0001;
        tick();
        chk_out("sat_grant0", gnt_d, v_d, id_d, pre_d, 4'b0001, 1'b0);
        for (int k = 0; k < 23; k++) begin
            tick();
            chk("sat_hold/gnt", 32'(gnt_d), 32'h1);
        end
        req_d = 4'b0011;
        tick();
        chk_out("sat_preempt", gnt_d, v_d, id_d, pre_d, 4'b0000, 1'b1);
        tick();
        chk_out("sat_grant1", gnt_d, v_d, id_d, pre_d, 4'b0010, 1'b0);
        req_d = 4'b0000;
        tick();
        chk_out("sat_idle", gnt_d, v_d, id_d, pre_d, 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
